ks_adder_pipe: RTL and testbench
================================

Name: ks_adder_pipe

Overview:
- Parametrised, pipelined Kogge-Stone adder/subtractor. It is the clocked successor of the combinational 32-bit Kogge-Stone adder.
- Arbitrary operand width, configurable pipeline depth, add/subtract mode, carry-in, signed-overflow flag and a tag pass-through.
- Valid/ready handshakes on both sides. It sits between operand-issue logic and a result consumer in datapath blocks that need a registered, back-pressurable adder.

Parameters:
- WIDTH, 32, operand width in bits (>= 2); LEVELS = clog2(WIDTH) prefix levels.
- LVLS_PER_STAGE, 2, prefix levels evaluated combinationally between pipeline registers (1..LEVELS).
- TAG_W, 4, width of the sideband tag carried alongside each operation (>= 1).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block accepts a beat this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_cin  input  1  carry-in (add mode only).
- in_sub  input  1  1 = A - B, 0 = A + B + cin.
- in_tag  input  TAG_W  sideband, returned unchanged with the result.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  WIDTH  result bits.
- out_cout  output  1  carry out of MSB (sub: 1 = no borrow).
- out_ovf  output  1  signed two's-complement overflow.
- out_tag  output  TAG_W  tag of this result.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: all valid bits 0, out_sum/out_cout/out_ovf/out_tag 0, in_ready 1 once rst_n deasserts.
- Operand preparation (combinational, before stage 1):
  - B' = in_sub ? ~in_b : in_b.
  - c0 = in_sub ? 1 : in_cin.
  - G0 = A & B', P0 = A ^ B'.
- Prefix network:
  - Kogge-Stone; level k (k = 0..LEVELS-1) has distance d = 2^k.
  - For i >= d: G[i] = G[i] | (P[i] & G[i-d]), P[i] = P[i] & P[i-d].
  - For i < d: pass through.
  - c0 is folded at the end: carry into bit i+1 = Gf[i] | (Pf[i] & c0).
- Pipeline structure:
  - NS = ceil(LEVELS / LVLS_PER_STAGE) register stages follow the prefix groups; one output register stage follows the sum XOR.
  - LATENCY = NS + 1 cycles from accepted input to out_valid, with no stall.
  - WIDTH=32, LVLS_PER_STAGE=2: NS=3, LATENCY=4.
  - Each stage register holds G, P, original P0, c0, sign bits A[W-1] and B'[W-1], tag, and a valid bit.
- Outputs:
  - out_sum[i] = P0[i] ^ carry_in_i, with carry_in_0 = c0.
  - out_cout = carry out of bit WIDTH-1.
  - out_ovf = (A[W-1] == B'[W-1]) && (out_sum[W-1] != A[W-1]).
- Handshake and flow control:
  - Global stall: adv = !out_valid || out_ready. All stage registers load only when adv = 1; in_ready = adv.
  - A beat is accepted when in_valid && in_ready. Bubbles (valid = 0) propagate and are not collapsed.
  - While adv = 0, every stage holds, and out_* stay stable until out_ready.
  - Simultaneous out_ready and in_valid with a full pipeline: one result leaves and one beat enters in the same cycle (full throughput, 1 op/cycle).
  - in_ready depends on out_ready combinationally; no combinational path from in_valid to out_*.
- Reset mid-operation: all in-flight beats are discarded and valids clear immediately (asynchronous). No partial result appears after rst_n deasserts.
- Width rules:
  - Non-power-of-two WIDTH is supported; prefix terms with i-d < 0 pass through.
  - Wrap-around is modulo 2^WIDTH; carry/borrow and overflow are reported only through out_cout/out_ovf.
- in_cin is ignored when in_sub = 1.

Decomposition:
- Package ks_pkg:
  - function clog2.
  - function ks_num_stages(WIDTH, LVLS_PER_STAGE).
  - packed struct ks_stage_t {g, p, p0, c0, sa, sb, tag, vld} parameterised via localparams in the top.
  - Stage-count and latency constants derived there.
- Sub-module ks_prefix_level: one combinational Kogge-Stone level, parameters WIDTH and DIST, ports g_in/p_in to g_out/p_out. The top generates LEVELS instances and inserts registers after every LVLS_PER_STAGE-th level and at the end of the last group.

Test Plan:
- Reset then single add, WIDTH=32: A=0xFFFFFFFF, B=0x00000001, cin=0, tag=3 -> after 4 cycles sum=0x00000000, cout=1, ovf=0, tag=3.
- Subtract: A=0x00000005, B=0x00000007, sub=1, cin=1 (ignored) -> sum=0xFFFFFFFE, cout=0, ovf=0. Then A=0x80000000, B=0x00000001, sub=1 -> sum=0x7FFFFFFF, cout=1, ovf=1.
- Back-to-back stream: 64 random beats with in_valid=1 and out_ready=1 every cycle -> 64 results in order, one per cycle, first at cycle 4, each equal to the reference model, tags in sequence.
- Back-pressure: out_ready=0 for 6 cycles with a full pipeline -> in_ready=0, out_sum/out_tag held constant. Releasing out_ready drains with no loss or duplication.
- Reset mid-stream: assert rst_n=0 with 3 beats in flight -> out_valid drops in the same cycle. After release, no stale result emerges and the next beat completes with correct latency.
- Parameter sweep: WIDTH=13, LVLS_PER_STAGE=1 (LEVELS=4, LATENCY=5) and WIDTH=64, LVLS_PER_STAGE=6 (LATENCY=2) -> exhaustive carry-chain patterns (all-propagate plus cin=1) give the correct sum and cout at the stated latency.

Source files
------------

// File: rtl/ks_pkg.sv
// Shared helpers for the pipelined Kogge-Stone adder: prefix depth, stage count and latency.
package ks_pkg;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      int unsigned v;
      result = 0;
      v = value - 1;
      while (v != 0) begin
         result++;
         v = v >> 1;
      end
      return result;
   endfunction

   function automatic int unsigned ks_num_stages(input int unsigned width,
                                                 input int unsigned lvls_per_stage);
      return (clog2(width) + lvls_per_stage - 1) / lvls_per_stage;
   endfunction

   function automatic int unsigned ks_latency(input int unsigned width,
                                              input int unsigned lvls_per_stage);
      return ks_num_stages(width, lvls_per_stage) + 1;
   endfunction

   // Index of the last prefix level evaluated in front of stage register `stage`.
   function automatic int unsigned ks_group_last(input int unsigned stage,
                                                 input int unsigned lvls_per_stage,
                                                 input int unsigned levels);
      int unsigned upper;
      upper = (stage + 1) * lvls_per_stage;
      return ((upper < levels) ? upper : levels) - 1;
   endfunction

   localparam int unsigned KsDefaultWidth   = 32;
   localparam int unsigned KsDefaultLps     = 2;
   localparam int unsigned KsDefaultStages  = ks_num_stages(KsDefaultWidth, KsDefaultLps);
   localparam int unsigned KsDefaultLatency = ks_latency(KsDefaultWidth, KsDefaultLps);

endpackage

// File: rtl/ks_prefix_level.sv
// One combinational Kogge-Stone prefix level: combines each (G,P) pair with the pair DIST below.
module ks_prefix_level #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DIST  = 1
) (
   input  logic [WIDTH-1:0] g_in,
   input  logic [WIDTH-1:0] p_in,
   output logic [WIDTH-1:0] g_out,
   output logic [WIDTH-1:0] p_out
);

   always_comb begin
      g_out = g_in;
      p_out = p_in;
      for (int i = int'(DIST); i < int'(WIDTH); i++) begin
         g_out[i] = g_in[i] | (p_in[i] & g_in[i-int'(DIST)]);
         p_out[i] = p_in[i] & p_in[i-int'(DIST)];
      end
   end

endmodule

// File: rtl/ks_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready flow control and a tag sideband.
// Carry-in is folded in after the prefix tree so the tree itself is carry-in independent.
module ks_adder_pipe
   import ks_pkg::*;
#(
   parameter int unsigned WIDTH          = 32,
   parameter int unsigned LVLS_PER_STAGE = 2,
   parameter int unsigned TAG_W          = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_sub,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf,
   output logic [TAG_W-1:0] out_tag
);

   localparam int unsigned LEVELS = clog2(WIDTH);
   localparam int unsigned NS     = ks_num_stages(WIDTH, LVLS_PER_STAGE);

   typedef struct packed {
      logic [WIDTH-1:0] g;
      logic [WIDTH-1:0] p;
      logic [WIDTH-1:0] p0;
      logic             c0;
      logic             sa;
      logic             sb;
      logic [TAG_W-1:0] tag;
      logic             vld;
   } ks_stage_t;

   logic             adv;
   logic [WIDTH-1:0] b_mod;
   ks_stage_t        prep;

   logic [WIDTH-1:0] lvl_g [LEVELS];
   logic [WIDTH-1:0] lvl_p [LEVELS];

   ks_stage_t stage_grp [NS];
   ks_stage_t stage_d   [NS];
   ks_stage_t stage_q   [NS];

   logic             out_valid_d, out_valid_q;
   logic [WIDTH-1:0] out_sum_d, out_sum_q;
   logic             out_cout_d, out_cout_q;
   logic             out_ovf_d, out_ovf_q;
   logic [TAG_W-1:0] out_tag_d, out_tag_q;

   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] sum_c;

   // Single global stall: the whole pipe advances only when the output slot can move.
   assign adv      = !out_valid_q || out_ready;
   assign in_ready = adv;

   always_comb begin
      b_mod     = in_sub ? ~in_b : in_b;
      prep.g    = in_a & b_mod;
      prep.p    = in_a ^ b_mod;
      prep.p0   = in_a ^ b_mod;
      prep.c0   = in_sub | in_cin;
      prep.sa   = in_a[WIDTH-1];
      prep.sb   = b_mod[WIDTH-1];
      prep.tag  = in_tag;
      prep.vld  = in_valid;
   end

   for (genvar k = 0; k < int'(LEVELS); k++) begin : g_level
      logic [WIDTH-1:0] g_src;
      logic [WIDTH-1:0] p_src;

      if (k == 0) begin : g_first
         assign g_src = prep.g;
         assign p_src = prep.p;
      end else if ((k % int'(LVLS_PER_STAGE)) == 0) begin : g_from_reg
         assign g_src = stage_q[k/int'(LVLS_PER_STAGE)-1].g;
         assign p_src = stage_q[k/int'(LVLS_PER_STAGE)-1].p;
      end else begin : g_chain
         assign g_src = lvl_g[k-1];
         assign p_src = lvl_p[k-1];
      end

      ks_prefix_level #(
         .WIDTH (WIDTH),
         .DIST  (1 << k)
      ) u_level (
         .g_in  (g_src),
         .p_in  (p_src),
         .g_out (lvl_g[k]),
         .p_out (lvl_p[k])
      );
   end

   for (genvar s = 0; s < int'(NS); s++) begin : g_stage
      localparam int unsigned Last = ks_group_last(s, LVLS_PER_STAGE, LEVELS);

      logic [WIDTH-1:0] p0;
      logic             c0;
      logic             sa;
      logic             sb;
      logic [TAG_W-1:0] tag;
      logic             vld;

      if (s == 0) begin : g_src_in
         assign p0  = prep.p0;
         assign c0  = prep.c0;
         assign sa  = prep.sa;
         assign sb  = prep.sb;
         assign tag = prep.tag;
         assign vld = prep.vld;
      end else begin : g_src_reg
         assign p0  = stage_q[s-1].p0;
         assign c0  = stage_q[s-1].c0;
         assign sa  = stage_q[s-1].sa;
         assign sb  = stage_q[s-1].sb;
         assign tag = stage_q[s-1].tag;
         assign vld = stage_q[s-1].vld;
      end

      assign stage_grp[s] = '{g: lvl_g[Last], p: lvl_p[Last], p0: p0, c0: c0,
                              sa: sa, sb: sb, tag: tag, vld: vld};
   end

   always_comb begin
      for (int s = 0; s < int'(NS); s++) begin
         stage_d[s] = adv ? stage_grp[s] : stage_q[s];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < int'(NS); s++) begin
            stage_q[s] <= '0;
         end
      end else begin
         for (int s = 0; s < int'(NS); s++) begin
            stage_q[s] <= stage_d[s];
         end
      end
   end

   // Gf/Pf span bits [i:0], so the carry into bit i+1 needs only c0 on top.
   always_comb begin
      carry[0] = stage_q[NS-1].c0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         carry[i+1] = stage_q[NS-1].g[i] | (stage_q[NS-1].p[i] & stage_q[NS-1].c0);
      end
      sum_c = stage_q[NS-1].p0 ^ carry[WIDTH-1:0];
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_sum_d   = out_sum_q;
      out_cout_d  = out_cout_q;
      out_ovf_d   = out_ovf_q;
      out_tag_d   = out_tag_q;
      if (adv) begin
         out_valid_d = stage_q[NS-1].vld;
         out_sum_d   = sum_c;
         out_cout_d  = carry[WIDTH];
         out_ovf_d   = (stage_q[NS-1].sa == stage_q[NS-1].sb) &&
                       (sum_c[WIDTH-1] != stage_q[NS-1].sa);
         out_tag_d   = stage_q[NS-1].tag;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_sum_q   <= '0;
         out_cout_q  <= 1'b0;
         out_ovf_q   <= 1'b0;
         out_tag_q   <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_sum_q   <= out_sum_d;
         out_cout_q  <= out_cout_d;
         out_ovf_q   <= out_ovf_d;
         out_tag_q   <= out_tag_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_sum   = out_sum_q;
   assign out_cout  = out_cout_q;
   assign out_ovf   = out_ovf_q;
   assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_ks_adder_pipe.sv
// Scoreboard bench for ks_adder_pipe: 32-bit main instance plus 13-bit and 64-bit sweep instances.
module tb_ks_adder_pipe;

   localparam int Lat32 = 4;
   localparam int Lat13 = 5;
   localparam int Lat64 = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [63:0] sum;
      logic        cout;
      logic        ovf;
      logic [3:0]  tag;
      int          due;
   } exp_t;

   typedef struct {
      logic [63:0] a;
      logic [63:0] b;
      logic        cin;
      logic        sub;
      logic [63:0] s;
      logic        co;
      logic        ov;
   } vec_t;

   exp_t q32[$];
   exp_t q13[$];
   exp_t q64[$];

   // 32-bit instance
   logic        in_valid = 1'b0, in_ready, in_cin = 1'b0, in_sub = 1'b0;
   logic [31:0] in_a = '0, in_b = '0;
   logic [3:0]  in_tag = '0;
   logic        out_valid, out_ready = 1'b1, out_cout, out_ovf;
   logic [31:0] out_sum;
   logic [3:0]  out_tag;

   ks_adder_pipe #(.WIDTH(32), .LVLS_PER_STAGE(2), .TAG_W(4)) u_dut32 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
      .out_cout(out_cout), .out_ovf(out_ovf), .out_tag(out_tag)
   );

   // 13-bit, one level per stage
   logic        in_valid_13 = 1'b0, in_ready_13, in_cin_13 = 1'b0, in_sub_13 = 1'b0;
   logic [12:0] in_a_13 = '0, in_b_13 = '0;
   logic [3:0]  in_tag_13 = '0;
   logic        out_valid_13, out_cout_13, out_ovf_13;
   logic [12:0] out_sum_13;
   logic [3:0]  out_tag_13;

   ks_adder_pipe #(.WIDTH(13), .LVLS_PER_STAGE(1), .TAG_W(4)) u_dut13 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_13), .in_ready(in_ready_13),
      .in_a(in_a_13), .in_b(in_b_13), .in_cin(in_cin_13), .in_sub(in_sub_13),
      .in_tag(in_tag_13), .out_valid(out_valid_13), .out_ready(1'b1),
      .out_sum(out_sum_13), .out_cout(out_cout_13), .out_ovf(out_ovf_13),
      .out_tag(out_tag_13)
   );

   // 64-bit, whole tree in one stage
   logic        in_valid_64 = 1'b0, in_ready_64, in_cin_64 = 1'b0, in_sub_64 = 1'b0;
   logic [63:0] in_a_64 = '0, in_b_64 = '0;
   logic [3:0]  in_tag_64 = '0;
   logic        out_valid_64, out_cout_64, out_ovf_64;
   logic [63:0] out_sum_64;
   logic [3:0]  out_tag_64;

   ks_adder_pipe #(.WIDTH(64), .LVLS_PER_STAGE(6), .TAG_W(4)) u_dut64 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_64), .in_ready(in_ready_64),
      .in_a(in_a_64), .in_b(in_b_64), .in_cin(in_cin_64), .in_sub(in_sub_64),
      .in_tag(in_tag_64), .out_valid(out_valid_64), .out_ready(1'b1),
      .out_sum(out_sum_64), .out_cout(out_cout_64), .out_ovf(out_ovf_64),
      .out_tag(out_tag_64)
   );

   vec_t v13[6] = '{
      '{64'h1FFF, 64'h0000, 1'b1, 1'b0, 64'h0000, 1'b1, 1'b0},
      '{64'h0AAA, 64'h1555, 1'b1, 1'b0, 64'h0000, 1'b1, 1'b0},
      '{64'h0AAA, 64'h1555, 1'b0, 1'b0, 64'h1FFF, 1'b0, 1'b0},
      '{64'h0FFF, 64'h0001, 1'b0, 1'b0, 64'h1000, 1'b0, 1'b1},
      '{64'h0000, 64'h0000, 1'b0, 1'b1, 64'h0000, 1'b1, 1'b0},
      '{64'h1000, 64'h0001, 1'b0, 1'b1, 64'h0FFF, 1'b1, 1'b1}
   };

   vec_t v64[6] = '{
      '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0},
      '{64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0},
      '{64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b0, 1'b0,
        64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0},
      '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1},
      '{64'h0, 64'h0, 1'b0, 1'b1, 64'h0, 1'b1, 1'b0},
      '{64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1}
   };

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end
   endtask

   task automatic compare_out(input string nm, input exp_t e, input logic [63:0] sum,
                              input logic cout, input logic ovf, input logic [3:0] tag);
      chk({nm, "_sum"}, sum, e.sum);
      chk({nm, "_cout"}, 64'(cout), 64'(e.cout));
      chk({nm, "_ovf"}, 64'(ovf), 64'(e.ovf));
      chk({nm, "_tag"}, 64'(tag), 64'(e.tag));
      if (e.due >= 0) chk({nm, "_latency_cycle"}, 64'(cyc), 64'(e.due));
   endtask

   function automatic exp_t mk(input logic [63:0] s, input logic co, input logic ov,
                               input logic [3:0] t);
      exp_t e;
      e.sum = s;
      e.cout = co;
      e.ovf = ov;
      e.tag = t;
      e.due = -1;
      return e;
   endfunction

   function automatic exp_t model32(input logic [31:0] a, input logic [31:0] b,
                                    input logic cin, input logic sub, input logic [3:0] tag);
      logic [31:0] bb;
      logic [32:0] full;
      bb = sub ? ~b : b;
      full = {1'b0, a} + {1'b0, bb} + {32'd0, (sub | cin)};
      return mk({32'd0, full[31:0]}, full[32], (a[31] == bb[31]) && (full[31] != a[31]), tag);
   endfunction

   // Monitors: pop and compare whenever a result is handed over.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (q32.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL w32_unexpected: got result %h tag %0d want none", out_sum, out_tag);
         end else begin
            compare_out("w32", q32.pop_front(), {32'd0, out_sum}, out_cout, out_ovf, out_tag);
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && out_valid_13) begin
         if (q13.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL w13_unexpected: got result %h want none", out_sum_13);
         end else begin
            compare_out("w13", q13.pop_front(), {51'd0, out_sum_13}, out_cout_13, out_ovf_13,
                        out_tag_13);
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && out_valid_64) begin
         if (q64.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL w64_unexpected: got result %h want none", out_sum_64);
         end else begin
            compare_out("w64", q64.pop_front(), out_sum_64, out_cout_64, out_ovf_64, out_tag_64);
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the beat is taken.
   task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic cin,
                         input logic sub, input logic [3:0] tag, input exp_t e,
                         input bit push, input bit timed);
      int n;
      in_a = a;
      in_b = b;
      in_cin = cin;
      in_sub = sub;
      in_tag = tag;
      in_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++;
         failures++;
         $display("FAIL w32_accept_timeout: in_ready got 0 want 1");
      end else if (push) begin
         e.due = timed ? cyc + Lat32 : -1;
         q32.push_back(e);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_empty();
      int n;
      n = 0;
      while ((q32.size() + q13.size() + q64.size()) != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      if ((q32.size() + q13.size() + q64.size()) != 0) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout: pending got %0d want 0",
                  q32.size() + q13.size() + q64.size());
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      exp_t hold_e;
      logic [31:0] a;
      logic [31:0] b;
      int seen;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_async_out_valid", 64'(out_valid), 64'd0);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_sum", 64'(out_sum), 64'd0);
      chk("rst_out_cout", 64'(out_cout), 64'd0);
      chk("rst_out_ovf", 64'(out_ovf), 64'd0);
      chk("rst_out_tag", 64'(out_tag), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;

      // Directed 32-bit vectors
      send32(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 4'd3, mk(64'h0, 1'b1, 1'b0, 4'd3), 1'b1, 1'b1);
      send32(32'h5, 32'h7, 1'b1, 1'b1, 4'd4, mk(64'hFFFF_FFFE, 1'b0, 1'b0, 4'd4), 1'b1, 1'b1);
      send32(32'h8000_0000, 32'h1, 1'b0, 1'b1, 4'd5, mk(64'h7FFF_FFFF, 1'b1, 1'b1, 4'd5),
             1'b1, 1'b1);
      send32(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 4'd6, mk(64'h8000_0000, 1'b0, 1'b1, 4'd6),
             1'b1, 1'b1);
      send32(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 4'd7,
             mk(64'h2345_678A, 1'b0, 1'b0, 4'd7), 1'b1, 1'b1);
      wait_empty();

      // Carry-chain sweep on the 13- and 64-bit instances
      for (int i = 0; i < 6; i++) begin
         in_a_13 = v13[i].a[12:0];
         in_b_13 = v13[i].b[12:0];
         in_cin_13 = v13[i].cin;
         in_sub_13 = v13[i].sub;
         in_tag_13 = 4'(i);
         in_valid_13 = 1'b1;
         in_a_64 = v64[i].a;
         in_b_64 = v64[i].b;
         in_cin_64 = v64[i].cin;
         in_sub_64 = v64[i].sub;
         in_tag_64 = 4'(i);
         in_valid_64 = 1'b1;
         @(negedge clk);
         chk("w13_in_ready", 64'(in_ready_13), 64'd1);
         chk("w64_in_ready", 64'(in_ready_64), 64'd1);
         e = mk(v13[i].s, v13[i].co, v13[i].ov, 4'(i));
         e.due = cyc + Lat13;
         q13.push_back(e);
         e = mk(v64[i].s, v64[i].co, v64[i].ov, 4'(i));
         e.due = cyc + Lat64;
         q64.push_back(e);
         @(posedge clk);
         #1;
      end
      in_valid_13 = 1'b0;
      in_valid_64 = 1'b0;
      wait_empty();

      // Back-to-back stream at full throughput
      for (int i = 0; i < 64; i++) begin
         a = $urandom;
         b = $urandom;
         send32(a, b, i[1], i[0], 4'(i), model32(a, b, i[1], i[0], 4'(i)), 1'b1, 1'b1);
      end
      wait_empty();

      // Back-pressure with a full pipeline
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         a = $urandom;
         b = $urandom;
         e = model32(a, b, 1'b0, 1'b0, 4'(8 + i));
         if (i == 0) hold_e = e;
         send32(a, b, 1'b0, 1'b0, 4'(8 + i), e, 1'b1, 1'b0);
      end
      for (int j = 0; j < 6; j++) begin
         @(negedge clk);
         chk("bp_in_ready", 64'(in_ready), 64'd0);
         chk("bp_out_valid", 64'(out_valid), 64'd1);
         chk("bp_sum_hold", 64'(out_sum), hold_e.sum);
         chk("bp_tag_hold", 64'(out_tag), 64'(hold_e.tag));
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      wait_empty();

      // Reset with beats in flight
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         send32(32'h100 + i, 32'h1, 1'b0, 1'b0, 4'(i), mk(64'h0, 1'b0, 1'b0, 4'd0), 1'b0,
                1'b0);
      end
      chk("pre_rst_out_valid", 64'(out_valid), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      chk("post_rst_no_stale", 64'(seen), 64'd0);
      @(posedge clk);
      #1;
      send32(32'h0000_0010, 32'h0000_0020, 1'b1, 1'b0, 4'd9,
             mk(64'h0000_0031, 1'b0, 1'b0, 4'd9), 1'b1, 1'b1);
      wait_empty();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
